// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: RAW stall FSM, taken-branch flush and saturating
// performance counters for stall cycles and branch flushes.
module hazard_control_unit #(
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             MEM_BranchTaken,
    input  logic             counter_clear,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             fsm_state
);

    // Handshake: none. Control outputs are Mealy functions of the registered
    // state and the current inputs; counters update on the rising clock edge.

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [1:0] bub_cnt;
    logic [1:0] bub_nxt;
    logic [1:0] n_bub;
    logic       m_ex;
    logic       m_mem;

    // Register $0 is hardwired to zero and can never be a true dependency.
    assign m_ex  = EX_RegWrite && (EX_WriteReg != 5'd0) &&
                   ((EX_WriteReg == ID_Rs) || (ID_UsesRt && (EX_WriteReg == ID_Rt)));
    assign m_mem = MEM_RegWrite && (MEM_WriteReg != 5'd0) &&
                   ((MEM_WriteReg == ID_Rs) || (ID_UsesRt && (MEM_WriteReg == ID_Rt)));

    always_comb begin
        n_bub = 2'd0;
        if (FORWARDING != 0) begin
            if (m_ex && EX_MemRead) n_bub = 2'd1;
        end else begin
            if (m_ex)       n_bub = 2'd2;
            else if (m_mem) n_bub = 2'd1;
        end
    end

    always_comb begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        stall_active = 1'b0;
        state_nxt    = state;
        bub_nxt      = bub_cnt;
        if (reset) begin
            state_nxt = RUN;
            bub_nxt   = 2'd0;
        end else if (MEM_BranchTaken) begin
            // A taken branch overrides everything, including a stall in flight.
            PC_Write     = 1'b1;
            IF_ID_Write  = 1'b1;
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            state_nxt    = RUN;
            bub_nxt      = 2'd0;
        end else if (state == STALL) begin
            ID_EX_Flush  = 1'b1;
            stall_active = 1'b1;
            bub_nxt      = bub_cnt - 2'd1;
            state_nxt    = (bub_cnt == 2'd1) ? RUN : STALL;
        end else if (n_bub != 2'd0) begin
            ID_EX_Flush  = 1'b1;
            stall_active = 1'b1;
            bub_nxt      = n_bub - 2'd1;
            state_nxt    = (n_bub > 2'd1) ? STALL : RUN;
        end else begin
            PC_Write    = 1'b1;
            IF_ID_Write = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            bub_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (counter_clear) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_active && (stall_cycles != CNT_MAX))
                stall_cycles <= stall_cycles + CNT_ONE;
            if (MEM_BranchTaken && (flush_events != CNT_MAX))
                flush_events <= flush_events + CNT_ONE;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three configurations share one stimulus stream
// and are compared every cycle against a bubble-count reference model.
module tb_hazard_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
    logic       ID_UsesRt, EX_MemRead, EX_RegWrite, MEM_RegWrite;
    logic       MEM_BranchTaken, counter_clear;

    logic [2:0]  pc_w, ifid_w, ifid_f, idex_f, exmem_f, stall_a, st;
    logic [15:0] sc0, fe0, sc1, fe1;
    logic [1:0]  sc2, fe2;

    int checks = 0;
    int errors = 0;

    hazard_control_unit #(.FORWARDING(1), .CNT_W(16)) u_fwd (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
        .MEM_BranchTaken(MEM_BranchTaken), .counter_clear(counter_clear),
        .PC_Write(pc_w[0]), .IF_ID_Write(ifid_w[0]), .IF_ID_Flush(ifid_f[0]),
        .ID_EX_Flush(idex_f[0]), .EX_MEM_Flush(exmem_f[0]), .stall_active(stall_a[0]),
        .stall_cycles(sc0), .flush_events(fe0), .fsm_state(st[0]));

    hazard_control_unit #(.FORWARDING(0), .CNT_W(16)) u_nofwd (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
        .MEM_BranchTaken(MEM_BranchTaken), .counter_clear(counter_clear),
        .PC_Write(pc_w[1]), .IF_ID_Write(ifid_w[1]), .IF_ID_Flush(ifid_f[1]),
        .ID_EX_Flush(idex_f[1]), .EX_MEM_Flush(exmem_f[1]), .stall_active(stall_a[1]),
        .stall_cycles(sc1), .flush_events(fe1), .fsm_state(st[1]));

    hazard_control_unit #(.FORWARDING(0), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg),
        .MEM_BranchTaken(MEM_BranchTaken), .counter_clear(counter_clear),
        .PC_Write(pc_w[2]), .IF_ID_Write(ifid_w[2]), .IF_ID_Flush(ifid_f[2]),
        .ID_EX_Flush(idex_f[2]), .EX_MEM_Flush(exmem_f[2]), .stall_active(stall_a[2]),
        .stall_cycles(sc2), .flush_events(fe2), .fsm_state(st[2]));

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: bubbles still owed, plus the two counters as integers.
    int fwd[3]  = '{1, 0, 0};
    int cmax[3] = '{65535, 65535, 3};
    int rem[3]  = '{0, 0, 0};
    int sc[3]   = '{0, 0, 0};
    int fe[3]   = '{0, 0, 0};
    int nrem[3] = '{0, 0, 0};
    int nsc[3]  = '{0, 0, 0};
    int nfe[3]  = '{0, 0, 0};

    function automatic int bubbles_needed(input int f);
        bit hit_ex, hit_mem;
        hit_ex  = EX_RegWrite && EX_WriteReg != 0 &&
                  (EX_WriteReg == ID_Rs || (ID_UsesRt && EX_WriteReg == ID_Rt));
        hit_mem = MEM_RegWrite && MEM_WriteReg != 0 &&
                  (MEM_WriteReg == ID_Rs || (ID_UsesRt && MEM_WriteReg == ID_Rt));
        if (f != 0) return (hit_ex && EX_MemRead) ? 1 : 0;
        if (hit_ex) return 2;
        return hit_mem ? 1 : 0;
    endfunction

    int e_pc, e_ifw, e_iff, e_idf, e_emf, e_sa, need, gsc, gfe;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 0; e_emf = 0; e_sa = 0;
            nrem[k] = rem[k];
            if (reset) begin
                nrem[k] = 0;
            end else if (MEM_BranchTaken) begin
                e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; e_emf = 1;
                nrem[k] = 0;
            end else if (rem[k] > 0) begin
                e_idf = 1; e_sa = 1;
                nrem[k] = rem[k] - 1;
            end else begin
                need = bubbles_needed(fwd[k]);
                if (need > 0) begin
                    e_idf = 1; e_sa = 1;
                    nrem[k] = need - 1;
                end else begin
                    e_pc = 1; e_ifw = 1;
                end
            end
            if (reset || counter_clear) begin
                nsc[k] = 0;
                nfe[k] = 0;
            end else begin
                nsc[k] = (e_sa == 1 && sc[k] < cmax[k]) ? sc[k] + 1 : sc[k];
                nfe[k] = (MEM_BranchTaken && fe[k] < cmax[k]) ? fe[k] + 1 : fe[k];
            end
            case (k)
                0:       begin gsc = int'(sc0); gfe = int'(fe0); end
                1:       begin gsc = int'(sc1); gfe = int'(fe1); end
                default: begin gsc = int'(sc2); gfe = int'(fe2); end
            endcase
            chk($sformatf("u%0d.PC_Write", k),     int'(pc_w[k]),    e_pc);
            chk($sformatf("u%0d.IF_ID_Write", k),  int'(ifid_w[k]),  e_ifw);
            chk($sformatf("u%0d.IF_ID_Flush", k),  int'(ifid_f[k]),  e_iff);
            chk($sformatf("u%0d.ID_EX_Flush", k),  int'(idex_f[k]),  e_idf);
            chk($sformatf("u%0d.EX_MEM_Flush", k), int'(exmem_f[k]), e_emf);
            chk($sformatf("u%0d.stall_active", k), int'(stall_a[k]), e_sa);
            chk($sformatf("u%0d.fsm_state", k),    int'(st[k]),      (rem[k] > 0) ? 1 : 0);
            chk($sformatf("u%0d.stall_cycles", k), gsc,              sc[k]);
            chk($sformatf("u%0d.flush_events", k), gfe,              fe[k]);
        end
    end

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                rem[k] <= 0; sc[k] <= 0; fe[k] <= 0;
            end else begin
                rem[k] <= nrem[k]; sc[k] <= nsc[k]; fe[k] <= nfe[k];
            end
        end
    end

    task automatic set_idle;
        ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0; EX_RegWrite = 0;
        EX_WriteReg = 0; MEM_RegWrite = 0; MEM_WriteReg = 0;
        MEM_BranchTaken = 0; counter_clear = 0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    // Drain any stall, then zero the counters; returns at the start of a fresh cycle.
    task automatic prep;
        set_idle;
        repeat (3) next_cycle;
        counter_clear = 1;
        next_cycle;
        counter_clear = 0;
    endtask

    task automatic ex_hazard_rt9;
        set_idle;
        EX_RegWrite = 1; EX_WriteReg = 9; ID_Rt = 9; ID_UsesRt = 1;
    endtask

    initial begin
        reset = 1;
        set_idle;
        repeat (2) @(posedge clk);
        #1;
        settle;
        chk("reset_pc_write", int'(pc_w[0]), 0);
        chk("reset_ifid_write", int'(ifid_w[1]), 0);
        chk("reset_stall_cycles", int'(sc0), 0);
        next_cycle;
        reset = 0;

        // Load-use with forwarding: exactly one bubble.
        prep;
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 8; ID_Rs = 8;
        settle;
        chk("lu_pc_write", int'(pc_w[0]), 0);
        chk("lu_ifid_write", int'(ifid_w[0]), 0);
        chk("lu_idex_flush", int'(idex_f[0]), 1);
        chk("lu_stall_active", int'(stall_a[0]), 1);
        next_cycle;
        set_idle;
        MEM_RegWrite = 1; MEM_WriteReg = 8; ID_Rs = 8;
        settle;
        chk("lu_after_pc_write", int'(pc_w[0]), 1);
        chk("lu_after_stall_cycles", int'(sc0), 1);

        // $0 load and a forwarded non-load never stall.
        prep;
        EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 0; ID_Rs = 0;
        settle;
        chk("zero_reg_pc_write", int'(pc_w[0]), 1);
        next_cycle;
        ex_hazard_rt9;
        settle;
        chk("nonload_pc_write", int'(pc_w[0]), 1);
        next_cycle;
        set_idle;
        settle;
        chk("nonload_stall_cycles", int'(sc0), 0);

        // No forwarding: EX match stalls twice.
        prep;
        ex_hazard_rt9;
        settle;
        chk("nf_ex_c1_pc_write", int'(pc_w[1]), 0);
        next_cycle;
        set_idle;
        settle;
        chk("nf_ex_c2_pc_write", int'(pc_w[1]), 0);
        chk("nf_ex_c2_state", int'(st[1]), 1);
        next_cycle;
        settle;
        chk("nf_ex_c3_pc_write", int'(pc_w[1]), 1);
        chk("nf_ex_stall_cycles", int'(sc1), 2);

        prep;
        ex_hazard_rt9;
        ID_UsesRt = 0;
        settle;
        chk("nf_no_rt_pc_write", int'(pc_w[1]), 1);
        next_cycle;
        set_idle;
        settle;
        chk("nf_no_rt_stall_cycles", int'(sc1), 0);

        prep;
        MEM_RegWrite = 1; MEM_WriteReg = 5; ID_Rs = 5;
        settle;
        chk("nf_mem_pc_write", int'(pc_w[1]), 0);
        chk("nf_mem_idex_flush", int'(idex_f[1]), 1);
        next_cycle;
        set_idle;
        settle;
        chk("nf_mem_after_pc_write", int'(pc_w[1]), 1);
        chk("nf_mem_stall_cycles", int'(sc1), 1);

        // Taken branch aborts a stall in progress.
        prep;
        ex_hazard_rt9;
        next_cycle;
        set_idle;
        MEM_BranchTaken = 1;
        settle;
        chk("br_ifid_flush", int'(ifid_f[1]), 1);
        chk("br_idex_flush", int'(idex_f[1]), 1);
        chk("br_exmem_flush", int'(exmem_f[1]), 1);
        chk("br_pc_write", int'(pc_w[1]), 1);
        chk("br_stall_active", int'(stall_a[1]), 0);
        next_cycle;
        set_idle;
        settle;
        chk("br_after_state", int'(st[1]), 0);
        chk("br_flush_events", int'(fe1), 1);
        chk("br_stall_cycles", int'(sc1), 1);
        chk("br_after_pc_write", int'(pc_w[1]), 1);

        // Reset during the STALL cycle.
        prep;
        ex_hazard_rt9;
        next_cycle;
        set_idle;
        #2;
        reset = 1;
        #1;
        chk("rst_mid_pc_write", int'(pc_w[1]), 0);
        chk("rst_mid_stall_cycles", int'(sc1), 0);
        chk("rst_mid_state", int'(st[1]), 0);
        next_cycle;
        reset = 0;
        settle;
        chk("rst_after_pc_write", int'(pc_w[1]), 1);
        chk("rst_after_state", int'(st[1]), 0);

        // Five single-bubble stalls saturate a 2-bit counter at 3.
        prep;
        MEM_RegWrite = 1; MEM_WriteReg = 5; ID_Rs = 5;
        repeat (5) next_cycle;
        set_idle;
        settle;
        chk("sat_stall_cycles", int'(sc2), 3);
        chk("sat_wide_stall_cycles", int'(sc1), 5);
        next_cycle;
        MEM_RegWrite = 1; MEM_WriteReg = 5; ID_Rs = 5; counter_clear = 1;
        settle;
        chk("clr_stall_active", int'(stall_a[2]), 1);
        next_cycle;
        set_idle;
        settle;
        chk("clr_stall_cycles", int'(sc2), 0);

        // Randomized traffic over a small register set for frequent matches.
        for (int i = 0; i < 3000; i++) begin
            next_cycle;
            reset           = ($urandom_range(0, 59) == 0);
            ID_Rs           = 5'($urandom_range(0, 3));
            ID_Rt           = 5'($urandom_range(0, 3));
            ID_UsesRt       = 1'($urandom_range(0, 1));
            EX_MemRead      = 1'($urandom_range(0, 1));
            EX_RegWrite     = 1'($urandom_range(0, 1));
            EX_WriteReg     = 5'($urandom_range(0, 3));
            MEM_RegWrite    = 1'($urandom_range(0, 1));
            MEM_WriteReg    = 5'($urandom_range(0, 3));
            MEM_BranchTaken = ($urandom_range(0, 9) == 0);
            counter_clear   = ($urandom_range(0, 39) == 0);
        end
        next_cycle;
        reset = 0;
        set_idle;
        repeat (3) next_cycle;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller; generates the stall and flush controls consumed by the PC register, the IF/ID buffer, the ID/EX buffer and the EX/MEM buffer.
- Detects RAW hazards between the instruction in ID and older producers in EX/MEM. On a hazard it holds PC and IF/ID and injects N bubbles into ID/EX via a multi-cycle stall FSM.
- A taken branch resolved in MEM flushes the younger stages and aborts any stall in progress.
- Keeps saturating performance counters for stall cycles and branch flushes.

Parameters:
- FORWARDING, 1: 1 means an EX/MEM/WB forwarding network exists, so only load-use stalls are needed. 0 means there is no forwarding and every RAW hazard stalls.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ID_Rs  input  5  rs field of the instruction in ID
- ID_Rt  input  5  rt field of the instruction in ID
- ID_UsesRt  input  1  the ID instruction reads rt (R-type, beq, sw)
- EX_MemRead  input  1  the EX instruction is a load
- EX_RegWrite  input  1  the EX instruction writes a register
- EX_WriteReg  input  5  destination of the EX instruction (after the RegDst mux)
- MEM_RegWrite  input  1  the MEM instruction writes a register
- MEM_WriteReg  input  5  destination of the MEM instruction
- MEM_BranchTaken  input  1  the branch in MEM is taken (Branch & Zero)
- counter_clear  input  1  synchronous clear of both performance counters
- PC_Write  output  1  PC load enable
- IF_ID_Write  output  1  IF/ID load enable
- IF_ID_Flush  output  1  zero IF/ID
- ID_EX_Flush  output  1  bubble into ID/EX
- EX_MEM_Flush  output  1  bubble into EX/MEM
- stall_active  output  1  a stall bubble is being injected this cycle
- stall_cycles  output  CNT_W  saturating count of stall cycles
- flush_events  output  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Registered state:
  - FSM state: RUN or STALL.
  - bub_cnt: 2 bits, remaining bubbles.
  - The two performance counters.
- Control outputs are combinational (Mealy) from the registered state and the current inputs.
- Reset (asynchronous, while high):
  - state=RUN, bub_cnt=0, stall_cycles=0, flush_events=0.
  - Outputs forced: PC_Write=0, IF_ID_Write=0, all flushes 0, stall_active=0.
  - Reset mid-stall abandons the stall with no residue.
- Match definitions:
  - mEX = EX_RegWrite & EX_WriteReg!=0 & (EX_WriteReg==ID_Rs | (ID_UsesRt & EX_WriteReg==ID_Rt)).
  - mMEM is the same expression using MEM_RegWrite and MEM_WriteReg.
  - Register $0 never causes a hazard.
- Bubble count N:
  - FORWARDING=1: N=1 if mEX & EX_MemRead, else 0.
  - FORWARDING=0: N=2 if mEX, else 1 if mMEM, else 0. mEX takes precedence. The register file writes first half and reads second half, so WB is never a hazard.
- Priority per cycle: MEM_BranchTaken > STALL continuation > new detection.
- MEM_BranchTaken=1, in any state:
  - IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Flush=1, PC_Write=1, IF_ID_Write=1, stall_active=0.
  - Next state RUN, bub_cnt cleared.
  - Hazard detection is ignored this cycle.
- RUN, no branch, N=0: PC_Write=1, IF_ID_Write=1, all flushes 0, stall_active=0.
- RUN, no branch, N>0 (first bubble):
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, stall_active=0→1.
  - bub_cnt<=N-1; next state STALL if N-1>0, else RUN.
- STALL, no branch:
  - Same outputs as the first bubble.
  - bub_cnt<=bub_cnt-1; next state RUN when bub_cnt==1.
  - Inputs are not re-evaluated in STALL.
- Bubble latency: a hazard produces exactly N consecutive stall cycles, starting in the detection cycle.
- stall_cycles increments on each clock edge with stall_active=1.
- flush_events increments on each edge with MEM_BranchTaken=1.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- counter_clear=1 sets both counters to 0 on the next edge. Clear wins over a simultaneous increment.
- Flushed IF/ID (all-zero instruction) yields rs=rt=0, so no false hazard is possible.

Test Plan:
- FORWARDING=1, EX_MemRead=1, EX_RegWrite=1, EX_WriteReg=8, ID_Rs=8 → one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Next cycle (producer now in MEM, EX cleared) all normal; stall_cycles=1.
- FORWARDING=1, a load to $0 with ID_Rs=0, or a non-load with EX_WriteReg=ID_Rt=9 → no stall, PC_Write=1 throughout.
- FORWARDING=0, EX_RegWrite=1, EX_WriteReg=9, ID_Rt=9, ID_UsesRt=1 → exactly 2 stall cycles, stall_cycles=2. Same stimulus with ID_UsesRt=0 → 0 stalls. MEM-only match → 1 stall.
- FORWARDING=0, 2-bubble stall; in the STALL cycle pulse MEM_BranchTaken=1 → IF_ID_Flush, ID_EX_Flush and EX_MEM_Flush=1, PC_Write=1, stall_active=0. Next cycle RUN, flush_events=1, stall_cycles=1.
- Assert reset during the STALL cycle → immediately PC_Write=0, counters 0. After release, with no hazard, PC_Write=1 and state RUN; no leftover bubble.
- CNT_W=2, 5 stall cycles → stall_cycles saturates at 3. counter_clear coincident with a stall cycle → 0 on the next edge.
